// File: rtl/apb_pkg.sv
// Shared types and helpers for the parameterised APB register-file slave.
package apb_pkg;

  // Bus phase seen by the slave in the current cycle.
  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // PSLVERR encodings.
  localparam logic APB_RESP_OKAY = 1'b0;
  localparam logic APB_RESP_ERR  = 1'b1;

  // Number of byte lanes on a bus of the given width.
  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Number of low address bits that select a byte inside a word.
  function automatic int align_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/apb_strb_mem.sv
// Word-organised register file with byte-strobed writes and a combinational read port.
module apb_strb_mem
  import apb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 64,
  parameter int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] strb,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  // Clear every word on reset; otherwise update only the strobed byte lanes of the addressed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem[w] <= '0;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb[b]) begin
          mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/apb_param_slave_mem.sv
// APB4 slave fronting a strobed register file, with programmable wait states and PSLVERR
// for out-of-range, misaligned and protocol-violating (IDLE->ACCESS) transfers.
module apb_param_slave_mem
  import apb_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    NUM_WORDS   = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                    p_clk,
  input  logic                    p_resetn,
  input  logic [ADDR_WIDTH-1:0]   p_addr,
  input  logic                    p_sel,
  input  logic                    p_enable,
  input  logic                    p_write,
  input  logic [DATA_WIDTH-1:0]   p_wdata,
  input  logic [DATA_WIDTH/8-1:0] p_strb,
  output logic [DATA_WIDTH-1:0]   p_rdata,
  output logic                    p_ready,
  output logic                    p_slverr
);

  localparam int                    STRB_W     = strb_width(DATA_WIDTH);
  localparam int                    IDX_W      = $clog2(NUM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(NUM_WORDS * STRB_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(STRB_W - 1);
  localparam int                    ALIGN_W    = align_bits(DATA_WIDTH);
  localparam logic [3:0]            WAIT_LIMIT = 4'(WAIT_STATES);

  // state_q remembers the phase of the previous cycle; a completed access is stored as IDLE
  // so that a following cycle with p_sel & p_enable still high is seen as an illegal entry.
  apb_state_e            state_q;
  apb_state_e            phase;
  logic [3:0]            cnt_q;
  logic                  illegal_q;
  logic                  illegal_now;
  logic [ADDR_WIDTH-1:0] off;
  logic [IDX_W-1:0]      word_idx;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  err;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_word;

  // Work out which bus phase this cycle is, and whether an access was entered without a SETUP.
  always_comb begin
    phase       = IDLE;
    illegal_now = 1'b0;
    if (p_sel) begin
      if (!p_enable) begin
        phase = SETUP;
      end else begin
        phase = ACCESS;
        case (state_q)
          SETUP:   illegal_now = 1'b0;
          ACCESS:  illegal_now = illegal_q;
          default: illegal_now = 1'b1;
        endcase
      end
    end
  end

  assign p_ready = p_resetn & (phase == ACCESS) & p_sel & p_enable & (cnt_q == WAIT_LIMIT);

  // Address decode: addresses below the base wrap to a huge offset and fall out of range.
  assign off          = p_addr - BASE_ADDR;
  assign word_idx     = IDX_W'(off >> ALIGN_W);
  assign out_of_range = (off >= MEM_BYTES);
  assign misaligned   = (ALIGN_W != 0) && ((p_addr & ALIGN_MASK) != '0);
  assign err          = out_of_range | misaligned | illegal_now;

  assign wr_en    = p_ready & p_write & ~err;
  assign p_rdata  = (p_ready & ~p_write & ~err) ? rd_word : '0;
  assign p_slverr = (p_ready & err) ? APB_RESP_ERR : APB_RESP_OKAY;

  // Track the transfer phase, count wait cycles while an access is stalled, and carry the
  // illegal-entry flag across those stalled cycles.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else if (phase == ACCESS && !p_ready) begin
      state_q   <= ACCESS;
      cnt_q     <= cnt_q + 4'd1;
      illegal_q <= illegal_now;
    end else begin
      state_q   <= (phase == ACCESS) ? IDLE : phase;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end
  end

  apb_strb_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk   (p_clk),
    .rst_n (p_resetn),
    .wr_en (wr_en),
    .idx   (word_idx),
    .wdata (p_wdata),
    .strb  (p_strb),
    .rdata (rd_word)
  );

endmodule

// File: tb/tb_apb_param_slave_mem.sv
// Directed bench for apb_param_slave_mem: three instances (32-bit no wait, 32-bit three
// wait states, 8-bit no wait) share one bus and are selected one at a time.
module tb_apb_param_slave_mem;

  logic        p_clk;
  logic        p_resetn;
  logic [31:0] p_addr;
  logic        p_enable;
  logic        p_write;
  logic [31:0] p_wdata;
  logic [3:0]  p_strb;
  logic        sel_a, sel_b, sel_c;

  logic [31:0] rdata_a, rdata_b;
  logic [7:0]  rdata_c;
  logic        ready_a, ready_b, ready_c;
  logic        err_a, err_b, err_c;

  int          cur_dev;
  logic [31:0] cur_rdata;
  logic        cur_ready;
  logic        cur_err;

  int num_checks;
  int num_errors;

  apb_param_slave_mem #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .NUM_WORDS (64), .BASE_ADDR (32'h0), .WAIT_STATES (0)
  ) dut_a (
    .p_clk (p_clk), .p_resetn (p_resetn), .p_addr (p_addr), .p_sel (sel_a),
    .p_enable (p_enable), .p_write (p_write), .p_wdata (p_wdata), .p_strb (p_strb),
    .p_rdata (rdata_a), .p_ready (ready_a), .p_slverr (err_a)
  );

  apb_param_slave_mem #(
    .DATA_WIDTH (32), .ADDR_WIDTH (32), .NUM_WORDS (64), .BASE_ADDR (32'h0), .WAIT_STATES (3)
  ) dut_b (
    .p_clk (p_clk), .p_resetn (p_resetn), .p_addr (p_addr), .p_sel (sel_b),
    .p_enable (p_enable), .p_write (p_write), .p_wdata (p_wdata), .p_strb (p_strb),
    .p_rdata (rdata_b), .p_ready (ready_b), .p_slverr (err_b)
  );

  apb_param_slave_mem #(
    .DATA_WIDTH (8), .ADDR_WIDTH (32), .NUM_WORDS (64), .BASE_ADDR (32'h0), .WAIT_STATES (0)
  ) dut_c (
    .p_clk (p_clk), .p_resetn (p_resetn), .p_addr (p_addr), .p_sel (sel_c),
    .p_enable (p_enable), .p_write (p_write), .p_wdata (p_wdata[7:0]), .p_strb (p_strb[0:0]),
    .p_rdata (rdata_c), .p_ready (ready_c), .p_slverr (err_c)
  );

  // Free-running bus clock, 10 time units per period.
  initial begin
    p_clk = 1'b0;
    forever #5 p_clk = ~p_clk;
  end

  // Route the selected instance's response onto common observation signals.
  always_comb begin
    cur_rdata = rdata_a;
    cur_ready = ready_a;
    cur_err   = err_a;
    if (cur_dev == 1) begin
      cur_rdata = rdata_b;
      cur_ready = ready_b;
      cur_err   = err_b;
    end else if (cur_dev == 2) begin
      cur_rdata = {24'h0, rdata_c};
      cur_ready = ready_c;
      cur_err   = err_c;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic set_sel(input int dev);
    cur_dev = dev;
    sel_a   = (dev == 0);
    sel_b   = (dev == 1);
    sel_c   = (dev == 2);
  endtask

  task automatic bus_idle();
    @(posedge p_clk);
    #1;
    sel_a    = 1'b0;
    sel_b    = 1'b0;
    sel_c    = 1'b0;
    p_enable = 1'b0;
  endtask

  // One full SETUP + ACCESS transfer; ends in the completing cycle so a following call is
  // back-to-back with no IDLE cycle in between.
  task automatic apply_stimulus(input string tag, input int dev, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] strb, input logic [31:0] exp_rdata,
                                input logic exp_err, input int exp_cycles);
    int   cycles;
    logic done;
    logic [31:0] got_rdata;
    logic got_err;
    @(posedge p_clk);
    #1;
    set_sel(dev);
    p_enable = 1'b0;
    p_write  = wr;
    p_addr   = addr;
    p_wdata  = wdata;
    p_strb   = strb;
    @(negedge p_clk);
    check_output({tag, "_setup_ready"}, {31'h0, cur_ready}, 32'h0);
    @(posedge p_clk);
    #1;
    p_enable  = 1'b1;
    cycles    = 0;
    done      = 1'b0;
    got_rdata = '0;
    got_err   = 1'b0;
    while (!done && cycles < 20) begin
      @(negedge p_clk);
      cycles++;
      if (cur_ready) begin
        done      = 1'b1;
        got_rdata = cur_rdata;
        got_err   = cur_err;
      end
    end
    check_output({tag, "_done"}, {31'h0, done}, 32'h1);
    check_output({tag, "_cycles"}, cycles, exp_cycles);
    check_output({tag, "_slverr"}, {31'h0, got_err}, {31'h0, exp_err});
    check_output({tag, "_rdata"}, got_rdata, exp_rdata);
  endtask

  // Directed test sequence.
  initial begin
    num_checks = 0;
    num_errors = 0;
    p_resetn   = 1'b0;
    p_addr     = '0;
    p_enable   = 1'b0;
    p_write    = 1'b0;
    p_wdata    = '0;
    p_strb     = '0;
    set_sel(0);
    sel_a = 1'b0;

    repeat (2) @(posedge p_clk);
    @(negedge p_clk);
    check_output("rst_ready", {31'h0, ready_a}, 32'h0);
    check_output("rst_slverr", {31'h0, err_a}, 32'h0);
    check_output("rst_rdata", rdata_a, 32'h0);
    @(posedge p_clk);
    #1;
    p_resetn = 1'b1;

    $display("[TB] basic write/read, 32-bit, no wait states");
    apply_stimulus("t1_wr", 0, 1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1);
    bus_idle();
    apply_stimulus("t1_rd", 0, 1'b0, 32'h8, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1);
    bus_idle();

    $display("[TB] byte strobes");
    apply_stimulus("t2_wr_all", 0, 1'b1, 32'h4, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 1);
    bus_idle();
    apply_stimulus("t2_wr_strb", 0, 1'b1, 32'h4, 32'h11223344, 4'b0101, 32'h0, 1'b0, 1);
    bus_idle();
    apply_stimulus("t2_rd", 0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hFF22FF44, 1'b0, 1);
    bus_idle();

    $display("[TB] error responses");
    apply_stimulus("t4_wr_range", 0, 1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0, 1'b1, 1);
    bus_idle();
    apply_stimulus("t4_wr_misal", 0, 1'b1, 32'h6, 32'h12345678, 4'hF, 32'h0, 1'b1, 1);
    bus_idle();
    apply_stimulus("t4_rd_keep", 0, 1'b0, 32'h4, 32'h0, 4'h0, 32'hFF22FF44, 1'b0, 1);
    bus_idle();
    apply_stimulus("t4_rd_word0", 0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    bus_idle();
    apply_stimulus("t4_rd_range", 0, 1'b0, 32'h100, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    bus_idle();

    $display("[TB] illegal entry straight into ACCESS");
    @(posedge p_clk);
    #1;
    set_sel(0);
    p_enable = 1'b1;
    p_write  = 1'b1;
    p_addr   = 32'h0;
    p_wdata  = 32'h00000055;
    p_strb   = 4'hF;
    @(negedge p_clk);
    check_output("ill_ready", {31'h0, cur_ready}, 32'h1);
    check_output("ill_slverr", {31'h0, cur_err}, 32'h1);
    bus_idle();
    apply_stimulus("ill_rd", 0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    bus_idle();

    $display("[TB] three wait states");
    apply_stimulus("t3_wr", 1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 4);
    bus_idle();
    apply_stimulus("t3_rd", 1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 4);
    bus_idle();

    $display("[TB] 8-bit instance");
    apply_stimulus("t5_wr", 2, 1'b1, 32'd63, 32'hA5, 4'h1, 32'h0, 1'b0, 1);
    bus_idle();
    apply_stimulus("t5_rd", 2, 1'b0, 32'd63, 32'h0, 4'h0, 32'hA5, 1'b0, 1);
    bus_idle();
    apply_stimulus("t5_rd_range", 2, 1'b0, 32'd64, 32'h0, 4'h0, 32'h0, 1'b1, 1);
    bus_idle();
    apply_stimulus("t5_wr_range", 2, 1'b1, 32'd64, 32'h3C, 4'h1, 32'h0, 1'b1, 1);
    bus_idle();
    apply_stimulus("t5_rd_word0", 2, 1'b0, 32'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    bus_idle();

    $display("[TB] reset in the middle of a stalled write");
    @(posedge p_clk);
    #1;
    set_sel(1);
    p_enable = 1'b0;
    p_write  = 1'b1;
    p_addr   = 32'h30;
    p_wdata  = 32'h77777777;
    p_strb   = 4'hF;
    @(posedge p_clk);
    #1;
    p_enable = 1'b1;
    @(posedge p_clk);
    #2;
    p_resetn = 1'b0;
    sel_a    = 1'b1;
    #1;
    check_output("t6_ready_b", {31'h0, ready_b}, 32'h0);
    check_output("t6_slverr_b", {31'h0, err_b}, 32'h0);
    check_output("t6_rdata_b", rdata_b, 32'h0);
    check_output("t6_ready_a", {31'h0, ready_a}, 32'h0);
    check_output("t6_slverr_a", {31'h0, err_a}, 32'h0);
    bus_idle();
    @(posedge p_clk);
    #1;
    p_resetn = 1'b1;
    apply_stimulus("t6_rd_aborted", 1, 1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 4);
    bus_idle();
    apply_stimulus("t6_rd_cleared", 1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 4);
    bus_idle();
    apply_stimulus("t6_rd_cleared_a", 0, 1'b0, 32'h8, 32'h0, 4'h0, 32'h0, 1'b0, 1);
    bus_idle();

    $display("[TB] back-to-back transfers");
    apply_stimulus("t7_wr0", 0, 1'b1, 32'h20, 32'hAAAA0001, 4'hF, 32'h0, 1'b0, 1);
    apply_stimulus("t7_wr1", 0, 1'b1, 32'h24, 32'hBBBB0002, 4'hF, 32'h0, 1'b0, 1);
    apply_stimulus("t7_rd0", 0, 1'b0, 32'h20, 32'h0, 4'h0, 32'hAAAA0001, 1'b0, 1);
    apply_stimulus("t7_rd1", 0, 1'b0, 32'h24, 32'h0, 4'h0, 32'hBBBB0002, 1'b0, 1);
    bus_idle();
    apply_stimulus("t7_b2b_wait0", 1, 1'b1, 32'h8, 32'h01020304, 4'hF, 32'h0, 1'b0, 4);
    apply_stimulus("t7_b2b_wait1", 1, 1'b0, 32'h8, 32'h0, 4'h0, 32'h01020304, 1'b0, 4);
    bus_idle();

    repeat (2) @(posedge p_clk);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
